cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter CACHE_LINE_WIDTH, default 6: byte-offset bits per line (64 B, 16 words).
REQ-002 SHALL have parameter TAG_WIDTH, default 20: tag bits, taken from the address MSBs.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  request; held with all cpu_* inputs stable until cpu_ack.
REQ-007 cpu_we / cpu_addr / cpu_wdata / cpu_be  in  1/ADDR_WIDTH/32/4  write flag, byte address, store data, byte enables.
REQ-008 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  32  load data, valid while cpu_ack.
REQ-009 ln_hit / ln_valid / ln_dirty  in  1 each; ln_tag  in  TAG_WIDTH; ln_rdData  in  32: line status and read data for cpu_addr.
REQ-010 ln_write  out  1; ln_wrOff  out  CACHE_LINE_WIDTH; ln_wrTag  out  TAG_WIDTH; ln_wrVaild, ln_wrDirty  out  1; ln_wrData  out  32; ln_wrByteEnable  out  4: line write port.
REQ-011 ln_lkupOff  out  CACHE_LINE_WIDTH; ln_lkupData  in  32: writeback read port.
REQ-012 mem_req, mem_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  32; mem_ack  in  1; mem_rdata  in  32: one word per accepted transfer.

Function
REQ-013 States SHALL be IDLE, COMPARE, WRITEBACK, REFILL.
REQ-014 IDLE: cpu_req=1 SHALL go to COMPARE next cycle; outputs are otherwise inactive.
REQ-015 COMPARE with ln_hit and a read SHALL assert cpu_ack and drive cpu_rdata=ln_rdData, then go to IDLE, giving a 2-cycle hit latency.
REQ-016 COMPARE with ln_hit and a write SHALL assert cpu_ack and pulse ln_write with wrOff=cpu_addr[CACHE_LINE_WIDTH-1:0], wrTag=ln_tag, wrVaild=1, wrDirty=1, wrData=cpu_wdata, wrByteEnable=cpu_be, then go to IDLE.
REQ-017 COMPARE on a miss SHALL go to WRITEBACK if ln_valid and ln_dirty, otherwise to REFILL; the word counter is cleared to 0.
REQ-018 The word counter SHALL be CACHE_LINE_WIDTH-2 bits wide; "last word" means counter = all ones.
REQ-019 WRITEBACK SHALL hold mem_req=1 and mem_we=1, with ln_lkupOff={cnt,2'b00} and mem_wdata=ln_lkupData.
REQ-020 In WRITEBACK, mem_addr SHALL be {ln_tag, cpu_addr[ADDR_WIDTH-TAG_WIDTH-1:CACHE_LINE_WIDTH], cnt, 2'b00}.
REQ-021 In WRITEBACK, each mem_ack SHALL increment cnt; mem_ack on the last word SHALL clear cnt and go to REFILL.
REQ-022 REFILL SHALL hold mem_req=1 and mem_we=0, with mem_addr={cpu_addr[ADDR_WIDTH-1:CACHE_LINE_WIDTH], cnt, 2'b00}.
REQ-023 In REFILL, each mem_ack SHALL pulse ln_write with wrOff={cnt,2'b00}, wrTag=cpu_addr tag, wrData=mem_rdata, wrByteEnable=4'hF, wrDirty=0.
REQ-024 In REFILL, wrVaild SHALL be 0 on every word except the last, where it is 1; the last word SHALL go to COMPARE, which then hits.
REQ-025 mem_ack in the same cycle mem_req first rises SHALL be accepted; mem_ack while mem_req=0 SHALL be ignored.
REQ-026 cpu_req dropped before cpu_ack is illegal; behaviour is undefined and the bench checks it by assertion.
REQ-027 ln_write SHALL never assert in IDLE or WRITEBACK.

Reset
REQ-028 rst_n=0 SHALL force IDLE, cnt=0, and cpu_ack, ln_write, mem_req, mem_we low immediately, including mid-WRITEBACK or mid-REFILL.
REQ-029 After reset release, the first cpu_req SHALL be served as a fresh request; no partial transfer resumes.

Structure
REQ-030 The state enumeration and default CACHE_LINE_WIDTH, TAG_WIDTH and ADDR_WIDTH SHALL live in shared package cache_pkg.
REQ-031 No sub-module; the cacheline storage is instantiated beside cache_ctrl by its parent, and the counter and FSM are inline.

Verification
REQ-032 Reset, then a read of 0x00001040 with ln_valid=0 -> 16 reads from 0x00001040 to 0x0000107C; wrVaild=1 only on the 16th; then cpu_ack with the word at 0x1040.
REQ-033 Write 0xDEADBEEF, be=4'b0011, to a hit address -> cpu_ack 2 cycles after cpu_req; line word low half = 0xBEEF; ln_dirty=1.
REQ-034 Miss on a dirty line with tag 0x00001 at index 1 -> 16 writes to 0x00001040 to 0x0000107C carrying line data, then 16 refill reads, then cpu_ack.
REQ-035 mem_ack delayed by 0 to 5 random cycles per word -> the same transfer order and data as with zero delay; no word lost or duplicated.
REQ-036 rst_n pulsed low at WRITEBACK word 7 -> mem_req=0 that cycle, state IDLE; a repeated request restarts at word 0.
REQ-037 Back-to-back hit reads to 0x1040 and 0x1044 -> two cpu_ack pulses, each 2 cycles after its cpu_req, with no mem_req.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the write-back cache controller: default geometry and FSM state encoding.
package cache_pkg;

  localparam int DEF_CACHE_LINE_WIDTH = 6;
  localparam int DEF_TAG_WIDTH        = 20;
  localparam int DEF_ADDR_WIDTH       = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_t;

endpackage

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate cache controller; drives a cacheline store that lives beside it
// and moves whole lines to/from memory one 32-bit word per accepted transfer.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
  parameter int TAG_WIDTH        = DEF_TAG_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic [3:0]                  cpu_be,
  output logic                        cpu_ack,
  output logic [31:0]                 cpu_rdata,
  input  logic                        ln_hit,
  input  logic                        ln_valid,
  input  logic                        ln_dirty,
  input  logic [TAG_WIDTH-1:0]        ln_tag,
  input  logic [31:0]                 ln_rdData,
  output logic                        ln_write,
  output logic [CACHE_LINE_WIDTH-1:0] ln_wrOff,
  output logic [TAG_WIDTH-1:0]        ln_wrTag,
  output logic                        ln_wrVaild,
  output logic                        ln_wrDirty,
  output logic [31:0]                 ln_wrData,
  output logic [3:0]                  ln_wrByteEnable,
  output logic [CACHE_LINE_WIDTH-1:0] ln_lkupOff,
  input  logic [31:0]                 ln_lkupData,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata
);

  localparam int CNT_W   = CACHE_LINE_WIDTH - 2;
  localparam int IDX_MSB = ADDR_WIDTH - TAG_WIDTH - 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;

  assign w_last = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    cpu_ack         = 1'b0;
    cpu_rdata       = '0;
    ln_write        = 1'b0;
    ln_wrOff        = '0;
    ln_wrTag        = '0;
    ln_wrVaild      = 1'b0;
    ln_wrDirty      = 1'b0;
    ln_wrData       = '0;
    ln_wrByteEnable = '0;
    ln_lkupOff      = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (r_state)
      IDLE: begin
        if (cpu_req) w_state_next = COMPARE;
      end

      COMPARE: begin
        if (ln_hit) begin
          cpu_ack      = 1'b1;
          cpu_rdata    = ln_rdData;
          w_state_next = IDLE;
          if (cpu_we) begin
            ln_write        = 1'b1;
            ln_wrOff        = cpu_addr[CACHE_LINE_WIDTH-1:0];
            ln_wrTag        = ln_tag;
            ln_wrVaild      = 1'b1;
            ln_wrDirty      = 1'b1;
            ln_wrData       = cpu_wdata;
            ln_wrByteEnable = cpu_be;
          end
        end else begin
          w_cnt_next   = '0;
          w_state_next = (ln_valid && ln_dirty) ? WRITEBACK : REFILL;
        end
      end

      WRITEBACK: begin
        // Victim address is rebuilt from the stored tag and the request's index.
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        ln_lkupOff = {r_cnt, 2'b00};
        mem_wdata  = ln_lkupData;
        mem_addr   = {ln_tag, cpu_addr[IDX_MSB:CACHE_LINE_WIDTH], r_cnt, 2'b00};
        if (mem_ack) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last) begin
            w_cnt_next   = '0;
            w_state_next = REFILL;
          end
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[ADDR_WIDTH-1:CACHE_LINE_WIDTH], r_cnt, 2'b00};
        if (mem_ack) begin
          // The line only becomes valid with its final word, so a cut-short refill never hits.
          ln_write        = 1'b1;
          ln_wrOff        = {r_cnt, 2'b00};
          ln_wrTag        = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          ln_wrVaild      = w_last;
          ln_wrDirty      = 1'b0;
          ln_wrData       = mem_rdata;
          ln_wrByteEnable = 4'hF;
          w_cnt_next      = r_cnt + 1'b1;
          if (w_last) begin
            w_cnt_next   = '0;
            w_state_next = COMPARE;
          end
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a behavioural line store and a word-per-ack memory surround the DUT.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        ln_hit, ln_valid, ln_dirty;
  logic [19:0] ln_tag;
  logic [31:0] ln_rdData;
  logic        ln_write;
  logic [5:0]  ln_wrOff;
  logic [19:0] ln_wrTag;
  logic        ln_wrVaild, ln_wrDirty;
  logic [31:0] ln_wrData;
  logic [3:0]  ln_wrByteEnable;
  logic [5:0]  ln_lkupOff;
  logic [31:0] ln_lkupData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ln_hit(ln_hit), .ln_valid(ln_valid), .ln_dirty(ln_dirty), .ln_tag(ln_tag), .ln_rdData(ln_rdData),
    .ln_write(ln_write), .ln_wrOff(ln_wrOff), .ln_wrTag(ln_wrTag), .ln_wrVaild(ln_wrVaild),
    .ln_wrDirty(ln_wrDirty), .ln_wrData(ln_wrData), .ln_wrByteEnable(ln_wrByteEnable),
    .ln_lkupOff(ln_lkupOff), .ln_lkupData(ln_lkupData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Line store: 64 sets x 16 words, indexed by the CPU address.
  logic [19:0] st_tag   [64];
  logic        st_valid [64];
  logic        st_dirty [64];
  logic [31:0] st_data  [64][16];
  logic        st_clear;
  logic [5:0]  idx;
  logic [3:0]  wrd;

  assign idx         = cpu_addr[11:6];
  assign wrd         = cpu_addr[5:2];
  assign ln_valid    = st_valid[idx];
  assign ln_dirty    = st_dirty[idx];
  assign ln_tag      = st_tag[idx];
  assign ln_hit      = st_valid[idx] && (st_tag[idx] == cpu_addr[31:12]);
  assign ln_rdData   = st_data[idx][wrd];
  assign ln_lkupData = st_data[idx][ln_lkupOff[5:2]];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (st_clear) begin
      for (int s = 0; s < 64; s++) begin
        st_tag[s]   <= '0;
        st_valid[s] <= 1'b0;
        st_dirty[s] <= 1'b0;
        for (int w = 0; w < 16; w++) st_data[s][w] <= '0;
      end
    end else if (ln_write) begin
      st_tag[idx]   <= ln_wrTag;
      st_valid[idx] <= ln_wrVaild;
      st_dirty[idx] <= ln_wrDirty;
      st_data[idx][ln_wrOff[5:2]] <= merge(st_data[idx][ln_wrOff[5:2]], ln_wrData, ln_wrByteEnable);
    end
  end

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  int total = 0;
  int bad   = 0;

  logic [31:0] tr_addr[$];
  logic [31:0] tr_wdata[$];
  logic        tr_we[$];
  logic        wr_vld[$];
  logic        wr_drt[$];
  logic [31:0] wr_data[$];
  logic [5:0]  wr_off[$];
  logic        got_ack;
  logic        req_at_ack;
  logic [31:0] ack_data;
  int          ack_lat;
  int          wr_in_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that takes cpu_ack.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int max_dly, input int rst_at);
    int dly;
    int cyc;
    bit done;
    tr_addr.delete(); tr_wdata.delete(); tr_we.delete();
    wr_vld.delete(); wr_drt.delete(); wr_data.delete(); wr_off.delete();
    got_ack = 1'b0; req_at_ack = 1'b0; ack_data = '0; ack_lat = 0; wr_in_wb = 0;
    dly  = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD0000;
      if (mem_req) begin
        if (rst_at >= 0 && mem_we && tr_addr.size() == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
          chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
          chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
          chk("rst_ln_write", {31'd0, ln_write}, 32'd0);
          cpu_req = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        if (dly == 0) begin
          mem_ack = 1'b1;
          if (!mem_we) mem_rdata = memval(mem_addr);
          tr_addr.push_back(mem_addr);
          tr_we.push_back(mem_we);
          tr_wdata.push_back(mem_wdata);
          dly = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
        end else begin
          dly--;
        end
      end else if (max_dly > 0) begin
        mem_ack = 1'($urandom_range(1, 0));
      end
      #1;
      if (ln_write) begin
        wr_vld.push_back(ln_wrVaild);
        wr_drt.push_back(ln_wrDirty);
        wr_data.push_back(ln_wrData);
        wr_off.push_back(ln_wrOff);
        if (mem_req && mem_we) wr_in_wb++;
      end
      if (cpu_ack) begin
        got_ack    = 1'b1;
        req_at_ack = cpu_req;
        ack_data   = cpu_rdata;
        ack_lat    = cyc + 1;
        done       = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    $display("req we=%0d addr=%08h ack=%0d lat=%0d rdata=%08h xfers=%0d lnwr=%0d",
             we, addr, got_ack, ack_lat, ack_data, tr_addr.size(), wr_vld.size());
  endtask

  task automatic chk_hit(input string nm, input logic [31:0] exp_data, input logic is_rd);
    chk({nm, "_ack"}, {31'd0, got_ack}, 32'd1);
    chk({nm, "_req_held"}, {31'd0, req_at_ack}, 32'd1);
    chk({nm, "_lat"}, ack_lat, 32'd2);
    chk({nm, "_no_mem"}, tr_addr.size(), 32'd0);
    if (is_rd) chk({nm, "_rdata"}, ack_data, exp_data);
  endtask

  // Refill: 16 reads from base, line writes only valid on the last, clean, carrying memval.
  task automatic chk_refill(input string nm, input int first, input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), tr_addr[first+i], base + 32'(4*i));
      chk($sformatf("%s_we%0d", nm, i), {31'd0, tr_we[first+i]}, 32'd0);
    end
    chk({nm, "_lnwr_cnt"}, wr_vld.size(), 32'd16);
    chk({nm, "_wr_in_wb"}, wr_in_wb, 32'd0);
    for (int i = 0; i < 16 && i < wr_vld.size(); i++) begin
      chk($sformatf("%s_vld%0d", nm, i), {31'd0, wr_vld[i]}, (i == 15) ? 32'd1 : 32'd0);
      chk($sformatf("%s_drt%0d", nm, i), {31'd0, wr_drt[i]}, 32'd0);
      chk($sformatf("%s_off%0d", nm, i), {26'd0, wr_off[i]}, 32'(4*i));
      chk($sformatf("%s_data%0d", nm, i), wr_data[i], {16'hC0DE, base[15:0] + 16'(4*i)});
    end
  endtask

  task automatic chk_wb(input string nm, input logic [31:0] base, input int sp_i, input logic [31:0] sp_d);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), tr_addr[i], base + 32'(4*i));
      chk($sformatf("%s_we%0d", nm, i), {31'd0, tr_we[i]}, 32'd1);
      chk($sformatf("%s_data%0d", nm, i), tr_wdata[i],
          (i == sp_i) ? sp_d : {16'hC0DE, base[15:0] + 16'(4*i)});
    end
  endtask

  initial begin
    rst_n = 1'b0; st_clear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("reset_ln_write", {31'd0, ln_write}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    st_clear = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // Cold read miss: refill 0x1040..0x107C, then hit.
    do_req(1'b0, 32'h0000_1040, '0, 4'h0, 0, -1);
    chk("t1_ack", {31'd0, got_ack}, 32'd1);
    chk("t1_xfers", tr_addr.size(), 32'd16);
    if (tr_addr.size() == 16) chk_refill("t1_rf", 0, 32'h0000_1040);
    chk("t1_rdata", ack_data, 32'hC0DE_1040);

    // Partial write hit.
    do_req(1'b1, 32'h0000_1044, 32'hDEAD_BEEF, 4'b0011, 0, -1);
    chk_hit("t2", '0, 1'b0);
    chk("t2_lnwr_cnt", wr_vld.size(), 32'd1);
    chk("t2_word", st_data[1][1], 32'hC0DE_BEEF);
    chk("t2_dirty", {31'd0, st_dirty[1]}, 32'd1);

    // Back-to-back hit reads.
    do_req(1'b0, 32'h0000_1040, '0, 4'h0, 0, -1);
    chk_hit("t3a", 32'hC0DE_1040, 1'b1);
    do_req(1'b0, 32'h0000_1044, '0, 4'h0, 0, -1);
    chk_hit("t3b", 32'hC0DE_BEEF, 1'b1);

    // Dirty miss: write back tag 0x00001 line, refill tag 0x00002.
    do_req(1'b0, 32'h0000_2040, '0, 4'h0, 0, -1);
    chk("t4_xfers", tr_addr.size(), 32'd32);
    if (tr_addr.size() == 32) begin
      chk_wb("t4_wb", 32'h0000_1040, 1, 32'hC0DE_BEEF);
      chk_refill("t4_rf", 16, 32'h0000_2040);
    end
    chk("t4_rdata", ack_data, 32'hC0DE_2040);

    // Dirty miss with 0..5 cycle memory latency and stray acks while idle.
    do_req(1'b1, 32'h0000_2048, 32'h1234_5678, 4'hF, 0, -1);
    chk_hit("t5w", '0, 1'b0);
    do_req(1'b0, 32'h0000_1040, '0, 4'h0, 5, -1);
    chk("t5_xfers", tr_addr.size(), 32'd32);
    if (tr_addr.size() == 32) begin
      chk_wb("t5_wb", 32'h0000_2040, 2, 32'h1234_5678);
      chk_refill("t5_rf", 16, 32'h0000_1040);
    end
    chk("t5_rdata", ack_data, 32'hC0DE_1040);

    // Reset at writeback word 7, then the same miss restarts from word 0.
    do_req(1'b1, 32'h0000_1050, 32'hCAFE_F00D, 4'hF, 0, -1);
    chk_hit("t6w", '0, 1'b0);
    do_req(1'b0, 32'h0000_3040, '0, 4'h0, 0, 7);
    chk("t6_abort_xfers", tr_addr.size(), 32'd7);
    chk("t6_abort_ack", {31'd0, got_ack}, 32'd0);
    do_req(1'b0, 32'h0000_3040, '0, 4'h0, 0, -1);
    chk("t6_xfers", tr_addr.size(), 32'd32);
    if (tr_addr.size() == 32) begin
      chk_wb("t6_wb", 32'h0000_1040, 4, 32'hCAFE_F00D);
      chk_refill("t6_rf", 16, 32'h0000_3040);
    end
    chk("t6_rdata", ack_data, 32'hC0DE_3040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
